// File: rtl/serializer.sv
// Parallel-to-serial converter: captures a word plus a length code and shifts the
// selected MSBs out one bit per clock, with a per-bit valid strobe and busy back-pressure.
module serializer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  // One extra bit so a full-length transfer (DATA_W bits) fits in the counter.
  localparam int unsigned CntW = MOD_W + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;    // remaining bits, next one to send at the MSB
  logic [CntW-1:0]   cnt_q;      // bits still to emit after the one on ser_data_o
  logic              ser_q;
  logic              ser_val_q;
  logic              busy_q;

  logic              mod_legal;
  logic              accept;
  logic [CntW-1:0]   len;

  // Decode the length code and decide whether this edge accepts a new word.
  always_comb begin
    mod_legal = (data_mod_i != MOD_W'(1)) && (data_mod_i != MOD_W'(2));
    accept    = data_val_i && !busy_q && mod_legal;
    len       = (data_mod_i == '0) ? CntW'(DATA_W) : {1'b0, data_mod_i};
  end

  // Transfer FSM with registered serial outputs; reset aborts any transfer.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      ser_q     <= 1'b0;
      ser_val_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // First bit goes out on this very edge, so the shifter holds the rest.
            state_q   <= StSend;
            ser_q     <= data_i[DATA_W-1];
            shift_q   <= {data_i[DATA_W-2:0], 1'b0};
            cnt_q     <= len - CntW'(1);
            ser_val_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StSend: begin
          if (cnt_q == '0) begin
            state_q   <= StIdle;
            ser_q     <= 1'b0;
            ser_val_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            ser_q   <= shift_q[DATA_W-1];
            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            cnt_q   <= cnt_q - CntW'(1);
          end
        end
      endcase
    end
  end

  assign ser_data_o     = ser_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed vector table, reset abort,
// busy protection and randomized traffic against a queue-based bit model.
module tb_serializer;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic [15:0] data_i;
  logic [3:0]  data_mod_i;
  logic        data_val_i;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  serializer #(.DATA_W(16), .MOD_W(4)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] word;
    int          len;
  } word_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    int          exp_len;
    logic [15:0] exp_word;   // expected bits, right-aligned
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int busy_cycles = 0;

  // Model: bits of the transfer in flight; front is the bit currently on the wire.
  bit    mq[$];
  word_t exp_words[$];
  word_t dut_words[$];
  logic [15:0] cur_word;
  int          cur_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] m);
    return (m != 4'd1) && (m != 4'd2);
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then check outputs.
  task automatic step();
    bit          busy_before;
    logic        v;
    logic [15:0] d;
    logic [3:0]  m;
    int          len;
    busy_before = (mq.size() != 0);
    v = data_val_i;
    d = data_i;
    m = data_mod_i;
    @(posedge clk_i);
    #1;
    if (busy_before) begin
      void'(mq.pop_front());
    end else if (v && legal(m)) begin
      len = (m == 4'd0) ? 16 : int'(m);
      for (int k = 0; k < len; k++) mq.push_back(d[15-k]);
      exp_words.push_back('{word: d >> (16 - len), len: len});
      n_acc++;
    end
    check("ser_data_val", {31'b0, ser_data_val_o}, {31'b0, mq.size() != 0});
    check("busy", {31'b0, busy_o}, {31'b0, mq.size() != 0});
    check("ser_data", {31'b0, ser_data_o}, {31'b0, (mq.size() != 0) ? mq[0] : 1'b0});
    if (busy_o) busy_cycles++;
    // Regroup the serial stream into words; words are separated by idle cycles.
    if (ser_data_val_o) begin
      cur_word = {cur_word[14:0], ser_data_o};
      cur_cnt++;
    end else if (cur_cnt > 0) begin
      dut_words.push_back('{word: cur_word, len: cur_cnt});
      cur_cnt  = 0;
      cur_word = '0;
    end
  endtask

  task automatic idle_steps(input int n);
    data_val_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{data: 16'hA5C3, mod: 4'd0,  exp_len: 16, exp_word: 16'hA5C3};
    vecs[1] = '{data: 16'hF000, mod: 4'd4,  exp_len: 4,  exp_word: 16'h000F};
    vecs[2] = '{data: 16'h8000, mod: 4'd3,  exp_len: 3,  exp_word: 16'h0004};
    vecs[3] = '{data: 16'hFFFF, mod: 4'd1,  exp_len: 0,  exp_word: 16'h0000};
    vecs[4] = '{data: 16'hFFFF, mod: 4'd2,  exp_len: 0,  exp_word: 16'h0000};
    vecs[5] = '{data: 16'h8001, mod: 4'd15, exp_len: 15, exp_word: 16'h4000};
    vecs[6] = '{data: 16'h7FFF, mod: 4'd5,  exp_len: 5,  exp_word: 16'h000F};

    cur_word   = '0;
    srst_i     = 1'b1;
    data_i     = '0;
    data_mod_i = '0;
    data_val_i = 1'b0;
    #2;
    check("reset_ser_data", {31'b0, ser_data_o}, 32'd0);
    check("reset_ser_val",  {31'b0, ser_data_val_o}, 32'd0);
    check("reset_busy",     {31'b0, busy_o}, 32'd0);
    #10 srst_i = 1'b0;   // released mid-cycle
    idle_steps(2);

    // Directed table.
    foreach (vecs[i]) begin
      dut_words.delete();
      busy_cycles = 0;
      data_i     = vecs[i].data;
      data_mod_i = vecs[i].mod;
      data_val_i = 1'b1;
      step();
      idle_steps(20);
      check($sformatf("vec%0d_busy_cycles", i), busy_cycles, vecs[i].exp_len);
      check($sformatf("vec%0d_word_count", i), dut_words.size(),
            (vecs[i].exp_len != 0) ? 1 : 0);
      if (dut_words.size() > 0 && vecs[i].exp_len != 0) begin
        check($sformatf("vec%0d_len", i), dut_words[0].len, vecs[i].exp_len);
        check($sformatf("vec%0d_word", i), {16'b0, dut_words[0].word},
              {16'b0, vecs[i].exp_word});
      end
    end

    // Asynchronous reset in the middle of a transfer.
    data_i     = 16'hFFFF;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    step();
    idle_steps(4);
    #2 srst_i = 1'b1;
    #1;
    check("abort_ser_data", {31'b0, ser_data_o}, 32'd0);
    check("abort_ser_val",  {31'b0, ser_data_val_o}, 32'd0);
    check("abort_busy",     {31'b0, busy_o}, 32'd0);
    mq.delete();
    cur_cnt = 0;
    @(posedge clk_i);
    #1;
    check("abort_hold_val", {31'b0, ser_data_val_o}, 32'd0);
    #3 srst_i = 1'b0;
    idle_steps(3);
    dut_words.delete();
    data_i     = 16'h00C0;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    step();
    idle_steps(20);
    check("post_reset_count", dut_words.size(), 1);
    if (dut_words.size() == 1)
      check("post_reset_word", {16'b0, dut_words[0].word}, 32'h00C0);

    // Busy protection: valid held high with changing data during a transfer.
    dut_words.delete();
    data_i     = 16'h1234;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      data_i     = 16'($urandom);
      data_mod_i = 4'($urandom_range(0, 15));
      step();
    end
    check("busy_fell", {31'b0, busy_o}, 32'd0);
    data_i     = 16'hBEEF;
    data_mod_i = 4'd0;
    step();
    idle_steps(20);
    check("busy_prot_count", dut_words.size(), 2);
    if (dut_words.size() == 2) begin
      check("busy_prot_word0", {16'b0, dut_words[0].word}, 32'h1234);
      check("busy_prot_len0",  dut_words[0].len, 16);
      check("busy_prot_word1", {16'b0, dut_words[1].word}, 32'hBEEF);
    end

    // Random traffic.
    dut_words.delete();
    exp_words.delete();
    n_acc = 0;
    for (int cyc = 0; cyc < 40000 && n_acc < 1000; cyc++) begin
      if (mq.size() == 0) data_val_i = ($urandom_range(0, 9) < 7);
      else                data_val_i = 1'($urandom_range(0, 1));
      data_i     = 16'($urandom);
      data_mod_i = 4'($urandom_range(0, 15));
      step();
    end
    idle_steps(20);
    check("rand_accepted", n_acc, 1000);
    check("rand_word_count", dut_words.size(), exp_words.size());
    for (int i = 0; i < dut_words.size() && i < exp_words.size(); i++) begin
      check($sformatf("rand_len%0d", i), dut_words[i].len, exp_words[i].len);
      check($sformatf("rand_word%0d", i), {16'b0, dut_words[i].word},
            {16'b0, exp_words[i].word});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
